// File: rtl/sqdiff_macc_nch.sv
// Multi-channel pipelined square/multiply-accumulate engine with per-window framing
// and saturating PW-bit accumulation; one result per window on the last sample.
module sqdiff_macc_nch #(
  parameter int W  = 16,
  parameter int PW = 48,
  parameter int CH = 4,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [CW-1:0]        in_ch,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [1:0]           mode,
  input  logic signed [W-1:0]  ain,
  input  logic signed [W-1:0]  bin,
  output logic                 out_valid,
  output logic [CW-1:0]        out_ch,
  output logic signed [PW-1:0] out_data,
  output logic                 out_ovf
);

  typedef struct packed {
    logic [CW-1:0] ch;
    logic          first;
    logic          last;
    logic [1:0]    mode;
  } tag_t;

  logic [4:1] vld_pipe;
  logic       in_ok;

  tag_t                  tag1, tag2, tag3, tag4;
  logic signed [W-1:0]   a1, b1;
  logic signed [W:0]     ax, bx, pa2, pb2;
  logic signed [2*W+1:0] prod3;
  logic signed [PW-1:0]  sum4;
  logic                  ovf4;

  logic signed [PW-1:0]  acc [CH];
  logic [CH-1:0]         ovf;

  logic signed [PW:0]    base, prod_x, sum;
  logic signed [PW-1:0]  sat;
  logic                  clamp, ovf_nxt;

  // Out-of-range channels never enter the pipeline, so they cannot touch state.
  assign in_ok = in_valid && ({1'b0, in_ch} < (CW+1)'(CH));

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[3:1], in_ok};
  end

  // Datapath registers carry no reset; the valid pipe gates every use.
  always_ff @(posedge clk) begin
    tag1  <= '{ch: in_ch, first: in_first, last: in_last, mode: mode};
    a1    <= ain;
    b1    <= bin;
    tag2  <= tag1;
    pa2   <= ax;
    pb2   <= bx;
    tag3  <= tag2;
    prod3 <= pa2 * pb2;
    tag4  <= tag3;
    sum4  <= sat;
    ovf4  <= ovf_nxt;
  end

  always_comb begin
    ax = {a1[W-1], a1};
    bx = {b1[W-1], b1};
    unique case (tag1.mode)
      2'd0:    bx = {a1[W-1], a1} - {b1[W-1], b1};
      2'd1:    bx = {a1[W-1], a1} + {b1[W-1], b1};
      2'd2:    bx = {b1[W-1], b1};
      default: bx = {a1[W-1], a1};
    endcase
    if (tag1.mode < 2'd2) ax = bx;
  end

  // Sum at PW+1 bits: a sign disagreement in the top two bits is the clamp condition.
  always_comb begin
    base    = tag3.first ? '0 : {acc[tag3.ch][PW-1], acc[tag3.ch]};
    prod_x  = {{(PW-2*W-1){prod3[2*W+1]}}, prod3};
    sum     = base + prod_x;
    clamp   = sum[PW] ^ sum[PW-1];
    sat     = sum[PW-1:0];
    if (clamp) sat = sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    ovf_nxt = ((!tag3.first) && ovf[tag3.ch]) || clamp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) acc[i] <= '0;
      ovf <= '0;
    end else if (vld_pipe[3]) begin
      acc[tag3.ch] <= sat;
      ovf[tag3.ch] <= ovf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= vld_pipe[4] && tag4.last;
      if (vld_pipe[4] && tag4.last) begin
        out_ch   <= tag4.ch;
        out_data <= sum4;
        out_ovf  <= ovf4;
      end
    end
  end

endmodule

// File: tb/tb_sqdiff_macc_nch.sv
// Directed-vector bench for sqdiff_macc_nch; expected window results are queued
// by the driver and matched by an independent output monitor.
module tb_sqdiff_macc_nch;
  localparam int W  = 16;
  localparam int PW = 35;
  localparam int CH = 5;
  localparam int CW = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [CW-1:0]        in_ch;
  logic                 in_first, in_last;
  logic [1:0]           mode;
  logic signed [W-1:0]  ain, bin;
  logic                 out_valid;
  logic [CW-1:0]        out_ch;
  logic signed [PW-1:0] out_data;
  logic                 out_ovf;

  sqdiff_macc_nch #(.W(W), .PW(PW), .CH(CH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch),
    .in_first(in_first), .in_last(in_last), .mode(mode),
    .ain(ain), .bin(bin), .out_valid(out_valid), .out_ch(out_ch),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                nm;
    logic [CW-1:0]        ch;
    logic signed [PW-1:0] data;
    logic                 ovf;
    int                   due;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Called at posedge+1; the sample is captured at the next edge and its
  // result is visible after the fourth edge following capture.
  task automatic send(input int ch, input int a, input int b, input int m,
                      input bit f, input bit l, input bit chk,
                      input longint xd, input bit xo, input string nm);
    in_valid = 1'b1;
    in_ch    = CW'(ch);
    ain      = W'(a);
    bin      = W'(b);
    mode     = 2'(m);
    in_first = f;
    in_last  = l;
    if (chk) sbq.push_back('{nm: nm, ch: CW'(ch), data: PW'(xd), ovf: xo, due: cyc + 5});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: ch=%0d data=%0d ovf=%0d at cyc %0d", out_ch, out_data, out_ovf, cyc);
      end else begin
        e = sbq.pop_front();
        if (out_ch !== e.ch || out_data !== e.data || out_ovf !== e.ovf || cyc != e.due) begin
          errors++;
          $display("FAIL %s: got ch=%0d data=%0d ovf=%0d cyc=%0d, want ch=%0d data=%0d ovf=%0d cyc=%0d",
                   e.nm, out_ch, out_data, out_ovf, cyc, e.ch, e.data, e.ovf, e.due);
        end
      end
    end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
      checks++;
      errors++;
      e = sbq.pop_front();
      $display("FAIL %s: no out_valid by cyc %0d, want data=%0d", e.nm, cyc, e.data);
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_ch = 3'd1; in_first = 1'b1; in_last = 1'b1;
    mode = 2'($urandom_range(3)); ain = W'($urandom); bin = W'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_ch !== '0 || out_data !== '0 || out_ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_outs: cyc %0d got v=%b ch=%0d data=%0d ovf=%b, want all 0",
                 i, out_valid, out_ch, out_data, out_ovf);
      end
    end
    @(posedge clk); #1;

    // mode 0 on ch0: 25 + 0 + 16
    send(0,  3, -2, 0, 1, 0, 0, 0, 0, "");
    send(0,  1,  1, 0, 0, 0, 0, 0, 0, "");
    send(0, -4,  0, 0, 0, 1, 1, 41, 0, "win_mode0");
    idle(8);

    // interleaved: ch0 mode 2 (6+20), ch1 mode 3 (49+9)
    send(0,  2, 3, 2, 1, 0, 0, 0, 0, "");
    send(1,  7, 9, 3, 1, 0, 0, 0, 0, "");
    send(0,  4, 5, 2, 0, 1, 1, 26, 0, "ilv_ch0");
    send(1, -3, 1, 3, 0, 1, 1, 58, 0, "ilv_ch1");
    idle(8);

    // single-sample window: (-65536)^2 = 2^32
    send(2, -32768, -32768, 1, 1, 1, 1, 64'sd4294967296, 0, "one_sample");
    idle(8);

    // four 2^32 terms overflow a 35-bit signed accumulator
    send(3, -32768, -32768, 1, 1, 0, 0, 0, 0, "");
    send(3, -32768, -32768, 1, 0, 0, 0, 0, 0, "");
    send(3, -32768, -32768, 1, 0, 0, 0, 0, 0, "");
    send(3, -32768, -32768, 1, 0, 1, 1, 64'sd17179869183, 1, "sat_clamp");
    send(3, 1, 0, 0, 1, 1, 1, 1, 0, "sat_recover");
    idle(8);

    // in-flight last sample must be killed by the reset pulse
    send(0, 5, 0, 0, 1, 0, 0, 0, 0, "");
    send(0, 6, 0, 0, 0, 1, 0, 0, 0, "");
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(0, 1, 0, 0, 1, 0, 0, 0, 0, "");
    send(CH, 9, 0, 0, 1, 1, 0, 0, 0, "");
    idle(1);
    send(0, 2, 0, 0, 0, 1, 1, 5, 0, "rst_bubble_badch");

    for (int i = 0; i < 20 && sbq.size() > 0; i++) idle(1);
    idle(4);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
